// File: rtl/dcache_sa.sv
// N-way set-associative, write-through, no-write-allocate data cache with line refill.
// Optional hit/miss/store counters are built when DCACHE_STATS_EN is defined.
module dcache_sa #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16,
  parameter int WAYS       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_wr
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, RESP, WRITE} state_t;

  state_t state, state_n;

  logic [SETS-1:0]   valid_q [WAYS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [DATA_W-1:0] data_q  [WAYS][SETS][LINE_WORDS];
  logic [WAY_W-1:0]  rr_q    [SETS];

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             unused_bits;

  assign req_off     = cpu_addr[2 +: OFF_W];
  assign req_idx     = cpu_addr[2+OFF_W +: IDX_W];
  assign req_tag     = cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_bits = ^cpu_addr[1:0];

  logic [WAYS-1:0]   hit_vec;
  logic [WAY_W-1:0]  hit_way;
  logic              hit;
  logic [DATA_W-1:0] hit_word;
  logic [WAY_W-1:0]  vict_way;
  logic              vict_evict;
  logic              vict_found;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
        hit_vec[w] = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
    hit      = |hit_vec;
    hit_word = data_q[hit_way][req_idx][req_off];
  end

  // Lowest invalid way wins; round-robin only when the whole set is valid.
  always_comb begin
    vict_found = 1'b0;
    vict_way   = rr_q[req_idx];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!vict_found && !valid_q[w][req_idx]) begin
        vict_found = 1'b1;
        vict_way   = WAY_W'(w);
      end
    end
    vict_evict = !vict_found;
  end

  logic [WAY_W-1:0] fill_way;
  logic             fill_evict;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [OFF_W-1:0] fill_off;
  logic [OFF_W-1:0] beat_q;

  logic start_fill, start_write, rd_hit, beat_ack, fill_done, write_done;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    cpu_stall   = 1'b0;
    cpu_rdata   = '0;
    start_fill  = 1'b0;
    start_write = 1'b0;
    rd_hit      = 1'b0;
    beat_ack    = 1'b0;
    fill_done   = 1'b0;
    write_done  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            cpu_stall   = 1'b1;
            start_write = 1'b1;
            state_n     = WRITE;
          end else if (hit) begin
            cpu_rdata = hit_word;
            rd_hit    = 1'b1;
          end else begin
            cpu_stall  = 1'b1;
            start_fill = 1'b1;
            state_n    = FILL;
          end
        end
      end
      FILL: begin
        cpu_stall = 1'b1;
        if (mem_req && mem_ack) begin
          beat_ack = 1'b1;
          if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
            fill_done = 1'b1;
            state_n   = RESP;
          end
        end
      end
      RESP: begin
        cpu_rdata = data_q[fill_way][fill_idx][fill_off];
        state_n   = IDLE;
      end
      WRITE: begin
        cpu_stall = !(mem_req && mem_ack);
        if (mem_req && mem_ack) begin
          write_done = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line storage carries no reset; only valid bits decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (start_write && hit) data_q[hit_way][req_idx][req_off] <= cpu_wdata;
    if (beat_ack)           data_q[fill_way][fill_idx][beat_q] <= mem_rdata;
    if (fill_done)          tag_q[fill_way][fill_idx] <= fill_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      beat_q     <= '0;
      fill_way   <= '0;
      fill_evict <= 1'b0;
      fill_idx   <= '0;
      fill_tag   <= '0;
      fill_off   <= '0;
      for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int unsigned s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      if (start_fill) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= {cpu_addr[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
        beat_q     <= '0;
        fill_way   <= vict_way;
        fill_evict <= vict_evict;
        fill_idx   <= req_idx;
        fill_tag   <= req_tag;
        fill_off   <= req_off;
      end
      if (start_write) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= cpu_wdata;
      end
      if (beat_ack) begin
        beat_q   <= beat_q + 1'b1;
        mem_addr <= mem_addr + ADDR_W'(4);
      end
      if (fill_done) begin
        mem_req                     <= 1'b0;
        valid_q[fill_way][fill_idx] <= 1'b1;
        if (fill_evict)
          rr_q[fill_idx] <= (WAYS == 1) ? '0 : WAY_W'(rr_q[fill_idx] + 1'b1);
      end
      if (write_done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wr     <= '0;
    end else begin
      if (rd_hit && stat_hits != '1)       stat_hits   <= stat_hits + 1'b1;
      if (start_fill && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
      if (write_done && stat_wr != '1)     stat_wr     <= stat_wr + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_sa.sv
// Randomized and directed bench for dcache_sa against a line-level reference model
// with a word-addressed backing memory that returns the address when never written.
module tb_dcache_sa;
  localparam int AW = 32, DW = 32, LW = 4, SETS = 16, WAYS = 2;

  logic          clk, rst, cpu_req, cpu_we, cpu_stall, mem_req, mem_we, mem_ack;
  logic [AW-1:0] cpu_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]   stat_hits, stat_misses, stat_wr;
`endif

  dcache_sa #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wr(stat_wr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: cache contents per set/way plus backing memory.
  bit          m_valid [SETS][WAYS];
  logic [31:0] m_tag   [SETS][WAYS];
  logic [31:0] m_line  [SETS][WAYS][LW];
  int          m_rr    [SETS];
  logic [31:0] mem_store [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : a;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  // Memory responder: acks each beat after ack_delay waiting cycles, logs beats, watches stability.
  int          ack_delay = 0;
  int          stable_err = 0;
  logic [31:0] b_addr [$];
  bit          b_we   [$];
  logic [31:0] b_data [$];

  initial begin
    bit          busy;
    int          wait_cnt;
    logic [31:0] cap_addr, cap_wd;
    bit          cap_we;
    busy = 0; wait_cnt = 0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!busy) begin
          busy = 1; wait_cnt = 0;
          cap_addr = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
        end else if (mem_addr !== cap_addr || mem_we !== cap_we || (cap_we && mem_wdata !== cap_wd)) begin
          stable_err++;
        end
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? '0 : mem_rd(mem_addr);
          b_addr.push_back(mem_addr);
          b_we.push_back(mem_we);
          b_data.push_back(mem_wdata);
          busy = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        busy = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 with cpu_req dropped.
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    int          s, t, o, w, v, n, exp_beats;
    logic [31:0] base, waddr, exp_rd, rd;
    bit          first_stall;
    s     = int'((addr / (4 * LW)) % SETS);
    t     = int'(addr / (4 * LW * SETS));
    o     = int'((addr / 4) % LW);
    base  = addr - (addr % (4 * LW));
    waddr = addr - (addr % 4);
    w = -1;
    for (int i = 0; i < WAYS; i++)
      if (m_valid[s][i] && m_tag[s][i] == t) w = i;
    exp_rd = '0;
    if (we) begin
      exp_beats = 1;
      mem_store[waddr] = wdata;
      if (w >= 0) m_line[s][w][o] = wdata;
    end else if (w >= 0) begin
      exp_beats = 0;
      exp_rd = m_line[s][w][o];
    end else begin
      exp_beats = LW;
      v = -1;
      for (int i = 0; i < WAYS; i++)
        if (!m_valid[s][i] && v < 0) v = i;
      if (v < 0) begin
        v = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = t;
      for (int i = 0; i < LW; i++) m_line[s][v][i] = mem_rd(base + 32'(4 * i));
      exp_rd = m_line[s][v][o];
    end
    b_addr.delete(); b_we.delete(); b_data.delete();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    check_eq("onehot_hit", 32'($onehot0(dut.hit_vec)), 32'd1);
    first_stall = cpu_stall;
    n = 0;
    while (cpu_stall && n < 300) begin
      @(negedge clk);
      n++;
    end
    rd = cpu_rdata;
    if (n >= 300) check_eq("stall_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    check_eq("first_stall", 32'(first_stall), 32'(we || w < 0));
    check_eq("n_beats", 32'(b_addr.size()), 32'(exp_beats));
    for (int i = 0; i < b_addr.size() && i < exp_beats; i++) begin
      check_eq("beat_addr", b_addr[i], we ? waddr : base + 32'(4 * i));
      check_eq("beat_we", 32'(b_we[i]), 32'(we));
      if (we) check_eq("beat_wdata", b_data[i], wdata);
    end
    if (!we) check_eq("rdata", rd, exp_rd);
  endtask

  task automatic apply_reset();
    rst = 1'b0; cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    logic [31:0] a;
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", 32'(cpu_stall), 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_eq("idle_noreq_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1;

    do_access(0, 32'h100, '0);
    do_access(0, 32'h104, '0);
    do_access(1, 32'h108, 32'hDEAD);
    do_access(0, 32'h108, '0);
    do_access(1, 32'h400, 32'h1234_5678);
    do_access(0, 32'h400, '0);

    apply_reset();
    do_access(0, 32'h000, '0);
    do_access(0, 32'h100, '0);
    do_access(0, 32'h200, '0);
    do_access(0, 32'h104, '0);
    do_access(0, 32'h00C, '0);

    ack_delay = 3;
    stable_err = 0;
    do_access(0, 32'h500, '0);
    do_access(1, 32'h504, 32'hCAFE_F00D);
    do_access(0, 32'h504, '0);
    check_eq("mem_stable", 32'(stable_err), 32'd0);

    ack_delay = 1;
    b_addr.delete(); b_we.delete(); b_data.delete();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
    n = 0;
    while (b_addr.size() < 2 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check_eq("second_beat_seen", 32'(n < 100), 32'd1);
    rst = 1'b0; cpu_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("midfill_rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("midfill_rst_stall", 32'(cpu_stall), 32'd0);
    check_eq("midfill_rst_addr", mem_addr, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    model_reset();
    do_access(0, 32'h304, '0);

    stable_err = 0;
    for (int i = 0; i < 300; i++) begin
      ack_delay = int'($urandom_range(0, 2));
      a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 1) << 4) | ($urandom_range(0, 3) << 2);
      do_access($urandom_range(0, 9) < 3, a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    check_eq("rand_mem_stable", 32'(stable_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got %0d exp %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
